// File: rtl/fifo_stream_pkg.sv
// Shared types and helpers for the FIFO-to-stream adapter.
// Optional per-word parity is enabled with FIFO_STREAM_PARITY_EN.
package fifo_stream_pkg;

  localparam int unsigned SKID_DEPTH         = 2;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned PARITY_MAX_W       = 256;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
`ifdef FIFO_STREAM_PARITY_EN
    logic                          parity;
`endif
  } buf_entry_t;

  // Zero-extension leaves the XOR unchanged, so one wide input serves every width.
  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: head is the output register, skid catches the word
// that arrives while the head is stalled.
module fifo_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter type entry_t = buf_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  entry_t     din_i,
  output entry_t     head_o,
  output logic [1:0] cnt_o
);

  localparam logic [1:0] FULL = 2'(SKID_DEPTH);

  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] cnt_after_pop;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    cnt_after_pop = cnt_q - {1'b0, pop_i};
    cnt_d         = cnt_after_pop + {1'b0, push_i};
    head_d        = head_q;
    skid_d        = skid_q;
    if (pop_i && (cnt_q == FULL)) begin
      head_d = skid_q;
    end
    if (push_i) begin
      if (cnt_after_pop == 2'd0) begin
        head_d = din_i;
      end else begin
        skid_d = din_i;
      end
    end
  end

  // NOTE: the two entries are a handful of flops, so they are reset to 0 along with the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      head_q <= head_d;
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o = head_q;
  assign cnt_o  = cnt_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= FULL);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && (cnt_after_pop == FULL)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && (cnt_q == 2'd0)));

endmodule

// File: rtl/fifo_stream_adapter.sv
// Reads a synchronous FIFO and presents its words on a valid/ready stream with
// frame delimiting. Define FIFO_STREAM_PARITY_EN to add the out_parity output.
module fifo_stream_adapter
  import fifo_stream_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int unsigned FRAME_LEN  = 4,
  localparam int unsigned CNT_W      = $clog2(FRAME_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
`ifdef FIFO_STREAM_PARITY_EN
  output logic                  out_parity,
`endif
  output logic [CNT_W-1:0]      frame_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
`ifdef FIFO_STREAM_PARITY_EN
    logic                  parity;
`endif
  } entry_t;

  entry_t           cap_entry;
  entry_t           head;
  logic [1:0]       buf_cnt;
  logic             pop;
  logic             inflight_q;
  logic [2:0]       occupancy;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign out_valid = (buf_cnt != 2'd0);
  assign pop       = out_valid && out_ready;

  // Words held plus the one already requested, after this cycle's pop; never exceeds 2.
  assign occupancy  = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = !fifo_empty && (occupancy < 3'd2);

  always_comb begin
    cap_entry      = '0;
    cap_entry.data = fifo_data;
`ifdef FIFO_STREAM_PARITY_EN
    cap_entry.parity = calc_parity(PARITY_MAX_W'(fifo_data));
`endif
  end

  fifo_skid_buf #(
    .entry_t (entry_t)
  ) u_buf (
    .clk    (clk),
    .rst_n  (rst),
    .push_i (inflight_q),
    .pop_i  (pop),
    .din_i  (cap_entry),
    .head_o (head),
    .cnt_o  (buf_cnt)
  );

  assign out_data  = head.data;
  assign out_last  = out_valid && (frame_cnt_q == LAST_IDX);
  assign frame_cnt = frame_cnt_q;
`ifdef FIFO_STREAM_PARITY_EN
  assign out_parity = head.parity;
`endif

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (pop) begin
      frame_cnt_d = out_last ? '0 : frame_cnt_q + CNT_W'(1);
    end
  end

  // Clearing inflight on reset drops any word the FIFO returns afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      inflight_q  <= fifo_rd_en;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Directed bench for fifo_stream_adapter with a behavioural FIFO and an
// in-order scoreboard; define FIFO_STREAM_PARITY_EN to exercise out_parity.
module tb_fifo_stream_adapter;

  localparam int DW = 8;
  localparam int FL = 4;
  localparam int CW = $clog2(FL + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] frame_cnt;
`ifdef FIFO_STREAM_PARITY_EN
  logic          out_parity;
`endif

  fifo_stream_adapter #(
    .DATA_WIDTH (DW),
    .FRAME_LEN  (FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
`ifdef FIFO_STREAM_PARITY_EN
    .out_parity (out_parity),
`endif
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int            model_fc = 0;
  int            rd_count = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;

  typedef struct {
    logic          ready;
    logic          rd_en;
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic [CW-1:0] fc;
  } vec_t;

  vec_t tbl[11];
  logic ready_pat[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: scoreboard the accepted word, model the FIFO's 1-cycle read latency.
  task automatic tick();
    logic          rd;
    logic [DW-1:0] w;
    #1;
    if (stall_prev) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, stall_data);
      check("stall_last", out_last, stall_last);
    end
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    stall_last = out_last;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        flag("extra_word");
      end else begin
        w = exp_q.pop_front();
        check("order", out_data, w);
        check("last", out_last, (model_fc == FL - 1));
        check("frame_cnt_at_pop", frame_cnt, model_fc);
        model_fc = (model_fc == FL - 1) ? 0 : model_fc + 1;
      end
    end
    rd = fifo_rd_en;
    if (rd) rd_count++;
    if (rd && fifo_q.size() == 0) flag("rd_while_empty");
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) flag(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           ready rd   valid data   last fc
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 3'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 3'd1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 3'd2};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h14, 1'b1, 3'd3};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 3'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 3'd1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h17, 1'b0, 3'd2};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h18, 1'b1, 3'd3};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0};
    ready_pat[0] = 1'b1;
    ready_pat[1] = 1'b0;
    ready_pat[2] = 1'b0;
    ready_pat[3] = 1'b1;

    rst        = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    out_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    rst = 1'b1;
    tick();

    // Full-rate streaming, cycle-exact against the table.
    for (int w = 0; w < 8; w++) push_word(8'h11 + 8'(w));
    for (int i = 0; i < 11; i++) begin
      out_ready = tbl[i].ready;
      #1;
      check($sformatf("t1_rd_en[%0d]", i), fifo_rd_en, tbl[i].rd_en);
      check($sformatf("t1_valid[%0d]", i), out_valid, tbl[i].valid);
      if (tbl[i].valid) check($sformatf("t1_data[%0d]", i), out_data, tbl[i].data);
      check($sformatf("t1_last[%0d]", i), out_last, tbl[i].last);
      check($sformatf("t1_fc[%0d]", i), frame_cnt, tbl[i].fc);
      tick();
    end

    // Back-pressure pattern 1,0,0,1.
    for (int w = 0; w < 8; w++) push_word(8'h11 + 8'(w));
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      out_ready = ready_pat[c % 4];
      tick();
    end
    if (exp_q.size() != 0) flag("t2_drain_timeout");
    out_ready = 1'b0;
    #1;
    check("t2_valid_idle", out_valid, 0);
    check("t2_frame_cnt", frame_cnt, 0);
    @(negedge clk);

    // Sink stalled: only two reads may be issued.
    rd_count = 0;
    for (int w = 0; w < 5; w++) push_word(8'h31 + 8'(w));
    repeat (6) tick();
    check("t3_reads_issued", rd_count, 2);
    check("t3_rd_en_held", fifo_rd_en, 0);
    check("t3_valid", out_valid, 1);
    check("t3_head", out_data, 8'h31);
    out_ready = 1'b1;
    drain("t3_drain_timeout", 30);
    check("t3_frame_cnt", frame_cnt, 1);

    // Reset with one word buffered and one in flight.
    out_ready = 1'b0;
    rd_count  = 0;
    push_word(8'h55);
    push_word(8'h66);
    tick();
    tick();
    check("t5_pre_valid", out_valid, 1);
    check("t5_pre_data", out_data, 8'h55);
    check("t5_pre_fc", frame_cnt, 1);
    check("t5_pre_reads", rd_count, 2);
    rst = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_fc", frame_cnt, 0);
    check("t5_rst_last", out_last, 0);
    check("t5_rst_data", out_data, 0);
    exp_q.delete();
    model_fc   = 0;
    stall_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick();
    check("t5_post_valid", out_valid, 0);

    // FIFO runs dry mid-frame, then resumes.
    push_word(8'hA0);
    push_word(8'hA1);
    push_word(8'hA2);
    drain("t4_drain_timeout", 20);
    for (int g = 0; g < 10; g++) begin
      #1;
      check($sformatf("t4_gap_fc[%0d]", g), frame_cnt, 3);
      check($sformatf("t4_gap_valid[%0d]", g), out_valid, 0);
      tick();
    end
    push_word(8'hA3);
    for (int c = 0; c < 10 && !out_valid; c++) tick();
    #1;
    check("t4_a3_data", out_data, 8'hA3);
    check("t4_a3_last", out_last, 1);
    drain("t4_a3_timeout", 10);
    check("t4_fc_wrap", frame_cnt, 0);

`ifdef FIFO_STREAM_PARITY_EN
    begin
      logic par_exp[2];
      par_exp[0] = 1'b0;
      par_exp[1] = 1'b1;
      out_ready  = 1'b0;
      push_word(8'h03);
      push_word(8'h07);
      repeat (3) tick();
      check("par_data0", out_data, 8'h03);
      check("par_bit0", out_parity, par_exp[0]);
      out_ready = 1'b1;
      tick();
      check("par_data1", out_data, 8'h07);
      check("par_bit1", out_parity, par_exp[1]);
      drain("par_drain_timeout", 10);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_stream_adapter.md
Name: fifo_stream_adapter

Overview:
- Downstream consumer of the team's synchronous FIFO. Drives the FIFO's rd_en, captures its registered read data, and presents the words on a valid/ready output stream.
- Hides the FIFO's 1-cycle read latency with a 2-entry skid buffer, so a continuously ready sink sees 1 word/cycle.
- Adds frame delimiting: out_last marks every FRAME_LEN-th word.
- Sits between the FIFO and packet/serial egress logic.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- FRAME_LEN, 4, words per frame; legal range 1..255.
- CNT_W, $clog2(FRAME_LEN+1), frame counter width (derived localparam, not overridable).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronous to clk externally.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read request. Read data appears on fifo_data in the cycle after the request.
- fifo_data  input  DATA_WIDTH  FIFO registered read data.
- out_valid  output  1  output word valid.
- out_ready  input  1  sink accepts the word.
- out_data  output  DATA_WIDTH  output word.
- out_last  output  1  final word of the current frame.
- frame_cnt  output  CNT_W  words already accepted in the current frame.

Behaviour:
- Reset (rst=0): buffer count=0, inflight=0, frame_cnt=0, out_valid=0, out_data=0, out_last=0. Buffer contents are cleared to 0.
- Reset takes effect asynchronously. A FIFO read in flight at reset is discarded, and no word is emitted for it.
- State:
  - 2-entry buffer: head is the output register, second is the skid entry; buf_cnt ranges 0..2.
  - inflight flag: set in the cycle after fifo_rd_en=1.
- Pop: pop = out_valid && out_ready.
- Read issue (combinational):
  - fifo_rd_en = !fifo_empty && (buf_cnt + inflight - pop) < 2.
  - fifo_rd_en is never asserted while fifo_empty=1.
- Capture: when inflight=1, fifo_data is written this cycle.
  - Goes to the head if, after the pop, the head is free.
  - Otherwise goes to the skid entry.
  - On a pop, the skid entry shifts to the head in the same cycle.
- Ordering: words leave in exact FIFO read order. No duplication, no loss under any out_ready pattern.
- Output signals:
  - out_valid = (buf_cnt != 0).
  - out_data and out_last hold stable while out_valid && !out_ready.
- Latency: FIFO non-empty with the adapter idle → fifo_rd_en in the same cycle → out_valid 2 cycles later.
- Throughput: with out_ready held at 1 and the FIFO non-empty, 1 word/cycle in steady state.
- Frame counting:
  - out_last = out_valid && (frame_cnt == FRAME_LEN-1).
  - On a pop, frame_cnt increments; it wraps to 0 when out_last is popped.
  - FRAME_LEN=1: out_last=1 on every valid word.
- Boundaries:
  - FIFO empties mid-frame: out_valid drops after the buffer drains; frame_cnt holds; the frame resumes when data returns.
  - Simultaneous capture, pop and new read: the buffer never exceeds 2 entries (guaranteed by the issue rule; checked by an assertion).
  - out_ready=1 while out_valid=0: ignored.

Optional Feature:
- Macro FIFO_STREAM_PARITY_EN.
- Defined:
  - Adds output out_parity (1 bit) = even parity (XOR) of out_data.
  - Computed at capture and stored alongside each buffer entry; stable with the data.
  - Reset value 0.
- Undefined: port and storage absent; all other behaviour identical.

Decomposition:
- Package fifo_stream_pkg:
  - localparam SKID_DEPTH=2.
  - typedef buf_entry_t: struct of data, plus parity when enabled.
  - function calc_parity.
- One sub-module, fifo_skid_buf: the 2-entry buffer with push/pop/count. The top level keeps the read-issue logic, inflight flag and frame counter.

Test Plan:
- FIFO preloaded with 0x11..0x18, out_ready=1 throughout → fifo_rd_en in cycles 0..7; out_data 0x11..0x18 on consecutive cycles from cycle 2; out_last on 0x14 and 0x18; frame_cnt back to 0.
- Same data, out_ready toggling 1,0,0,1 repeating → identical word order, no drops or duplicates, out_data stable during stalls, buf_cnt ≤ 2 at all times.
- out_ready=0 with the FIFO holding 5 words → exactly 2 reads issued, then fifo_rd_en=0; releasing out_ready then drains all 5 words in order.
- 3 words (0xA0..0xA2), FIFO then empty 10 cycles, then 0xA3 → out_last only on 0xA3; frame_cnt holds 3 during the gap.
- rst pulsed low while a read is in flight and buf_cnt=1 → out_valid=0, frame_cnt=0 immediately; the in-flight word is never emitted; normal operation resumes after rst=1.
- With FIFO_STREAM_PARITY_EN: words 0x03, 0x07 → out_parity 0, 1.
